// File: rtl/matrix8x8_scan_reader.sv
// 8x8 key matrix scanner: walks the row select, debounces each row's column
// returns and reports every changed key as a press/release event.
module matrix8x8_scan_reader #(
  parameter int SCAN_DIV = 8192,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  colin,
  output logic [2:0]  scanout,
  output logic [63:0] keymap,
  output logic        key_valid,
  output logic [5:0]  key_code,
  output logic        key_press,
  output logic        frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0] CNT_MAX = 3'(DEBOUNCE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_REPORT
  } state_t;

  logic [7:0]       col_meta_reg;
  logic [7:0]       sync_col;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [2:0]       scan_reg;
  logic             sample_tick;
  logic [7:0]       sample;
  logic [7:0]       row_commit;
  logic             commit;
  logic [7:0]       cur_diff;

  state_t     state_reg, state_next;
  logic [7:0] diff_reg, diff_next;
  logic [2:0] row_reg, row_next;
  logic [7:0] val_reg, val_next;
  logic [2:0] low_col;

  // Column returns are asynchronous to clk; two flops before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_reg <= 8'hFF;
      sync_col     <= 8'hFF;
    end else begin
      col_meta_reg <= colin;
      sync_col     <= col_meta_reg;
    end
  end

  assign sample_tick = (div_cnt_reg == DIV_LAST);
  assign sample      = ~sync_col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
      scan_reg    <= 3'd0;
    end else if (sample_tick) begin
      div_cnt_reg <= '0;
      scan_reg    <= scan_reg + 3'd1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign scanout    = scan_reg;
  assign frame_done = sample_tick && (scan_reg == 3'd7);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      logic [7:0] raw_prev_reg;
      logic [2:0] stab_cnt_reg;
      logic [7:0] keymap_row_reg;
      logic       row_sel;
      logic       same;
      logic [2:0] cnt_next;

      assign row_sel  = sample_tick && (scan_reg == 3'(gi));
      assign same     = (sample == raw_prev_reg);
      // A differing sample restarts the run; identical samples saturate.
      assign cnt_next = !same ? 3'd0 :
                        (stab_cnt_reg == CNT_MAX) ? CNT_MAX : stab_cnt_reg + 3'd1;
      assign row_commit[gi] = row_sel && same && (cnt_next == CNT_MAX);
      assign keymap[gi*8 +: 8] = keymap_row_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          raw_prev_reg   <= 8'd0;
          stab_cnt_reg   <= 3'd0;
          keymap_row_reg <= 8'd0;
        end else if (row_sel) begin
          raw_prev_reg <= sample;
          stab_cnt_reg <= cnt_next;
          if (row_commit[gi]) begin
            keymap_row_reg <= sample;
          end
        end
      end
    end
  endgenerate

  assign commit   = |row_commit;
  assign cur_diff = sample ^ keymap[{scan_reg, 3'b000} +: 8];

  always_comb begin
    low_col = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (diff_reg[i]) begin
        low_col = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      diff_reg  <= 8'd0;
      row_reg   <= 3'd0;
      val_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      diff_reg  <= diff_next;
      row_reg   <= row_next;
      val_reg   <= val_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    diff_next  = diff_reg;
    row_next   = row_reg;
    val_next   = val_reg;
    key_valid  = 1'b0;
    key_code   = 6'd0;
    key_press  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_REPORT: begin
        key_valid = 1'b1;
        key_code  = {row_reg, low_col};
        key_press = val_reg[low_col];
        diff_next = diff_reg & (diff_reg - 8'd1);
        if (diff_next == 8'd0) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Reporting always drains well before the next sample, so a new commit
    // simply reloads the event set.
    if (commit && (cur_diff != 8'd0)) begin
      state_next = ST_REPORT;
      diff_next  = cur_diff;
      row_next   = scan_reg;
      val_next   = sample;
    end
  end

endmodule

// File: tb/tb_matrix8x8_scan_reader.sv
// Randomized self-checking bench for matrix8x8_scan_reader against a
// cycle-count / run-length reference model of the key matrix scanner.
module tb_matrix8x8_scan_reader;

  localparam int SD    = 16;
  localparam int DB    = 4;
  localparam int FRAME = SD * 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] keys = 64'd0;
  logic [7:0]  colin;
  logic [2:0]  scanout;
  logic [63:0] keymap;
  logic        key_valid;
  logic [5:0]  key_code;
  logic        key_press;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // The matrix: the selected row's closed keys pull their columns low.
  assign colin = ~keys[{scanout, 3'b000} +: 8];

  matrix8x8_scan_reader #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk),
    .reset(reset),
    .colin(colin),
    .scanout(scanout),
    .keymap(keymap),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_press(key_press),
    .frame_done(frame_done)
  );

  // Reference model: cycle count since reset, run length of identical
  // samples per row, and a queue of expected events stamped with their cycle.
  typedef struct {
    int         cyc;
    logic [5:0] code;
    logic       press;
  } ev_t;

  ev_t         ev_q[$];
  int          mc;
  logic [7:0]  m_meta, m_sync;
  logic [7:0]  m_last[8];
  int          m_run[8];
  logic [63:0] m_keymap;

  always @(posedge clk or posedge reset) begin : model
    logic [7:0] smp;
    int r, n;
    if (reset) begin
      mc = 0;
      m_meta = 8'hFF;
      m_sync = 8'hFF;
      m_keymap = 64'd0;
      for (int i = 0; i < 8; i++) begin
        m_last[i] = 8'd0;
        m_run[i]  = 1;
      end
      ev_q.delete();
    end else begin
      if ((mc % SD) == SD - 1) begin
        r = (mc / SD) % 8;
        smp = ~m_sync;
        if (smp == m_last[r]) m_run[r]++;
        else begin
          m_last[r] = smp;
          m_run[r]  = 1;
        end
        if (m_run[r] >= DB) begin
          n = 0;
          for (int c = 0; c < 8; c++) begin
            if (smp[c] != m_keymap[r*8 + c]) begin
              ev_q.push_back('{mc + 1 + n, 6'(r*8 + c), smp[c]});
              n++;
            end
          end
          m_keymap[r*8 +: 8] = smp;
        end
      end
      m_sync = m_meta;
      m_meta = colin;
      mc++;
      while (ev_q.size() > 0 && ev_q[0].cyc < mc) void'(ev_q.pop_front());
    end
  end

  wire [75:0] obs_vec = {scanout, keymap, key_valid,
                         key_valid ? key_code : 6'd0,
                         key_valid ? key_press : 1'b0, frame_done};

  function automatic logic [75:0] exp_vec();
    logic v;
    logic [5:0] c;
    logic p;
    v = 1'b0; c = 6'd0; p = 1'b0;
    if (ev_q.size() > 0 && ev_q[0].cyc == mc) begin
      v = 1'b1; c = ev_q[0].code; p = ev_q[0].press;
    end
    return {3'((mc / SD) % 8), m_keymap, v, c, p, (mc % FRAME) == FRAME - 1};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (scanout !== 3'd0) $display("FAIL reset_scanout: got %0d want 0", scanout); else n_pass++;
    n_checks++; if (keymap !== 64'd0) $display("FAIL reset_keymap: got %h want 0", keymap); else n_pass++;
    n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", key_valid); else n_pass++;
    n_checks++; if (key_code !== 6'd0) $display("FAIL reset_key_code: got %0d want 0", key_code); else n_pass++;
    n_checks++; if (key_press !== 1'b0) $display("FAIL reset_key_press: got %b want 0", key_press); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    reset = 1'b0;
    $display("reset: released at mc=%0d", mc);
  endtask

  task automatic test_idle_scan();
    int frames = 0, exp_frames = 0, valids = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec()) $display("FAIL idle_cycle mc=%0d: got %h want %h", mc, obs_vec, exp_vec()); else n_pass++;
      if (frame_done === 1'b1) frames++;
      if ((mc % FRAME) == FRAME - 1) exp_frames++;
      if (key_valid !== 1'b0) valids++;
    end
    n_checks++; if (frames != exp_frames) $display("FAIL idle_frames: got %0d want %0d", frames, exp_frames); else n_pass++;
    n_checks++; if (valids != 0) $display("FAIL idle_valids: got %0d want 0", valids); else n_pass++;
    $display("idle_scan: frames=%0d valids=%0d", frames, valids);
  endtask

  task automatic test_single_press();
    int evs = 0, ev19 = 0;
    keys[19] = 1'b1;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec()) $display("FAIL press_cycle mc=%0d: got %h want %h", mc, obs_vec, exp_vec()); else n_pass++;
      if (key_valid === 1'b1) begin
        evs++;
        if (key_code === 6'd19 && key_press === 1'b1) ev19++;
      end
    end
    n_checks++; if (evs != 1 || ev19 != 1) $display("FAIL press_events: got %0d (code19 %0d) want 1", evs, ev19); else n_pass++;
    n_checks++; if (keymap !== (64'd1 << 19)) $display("FAIL press_keymap: got %h want %h", keymap, 64'd1 << 19); else n_pass++;
    $display("single_press: events=%0d keymap=%h", evs, keymap);
  endtask

  task automatic test_bounce();
    int valids = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((mc % FRAME) == 0) keys[19] = ~keys[19];
      n_checks++; if (obs_vec !== exp_vec()) $display("FAIL bounce_cycle mc=%0d: got %h want %h", mc, obs_vec, exp_vec()); else n_pass++;
      if (key_valid !== 1'b0) valids++;
    end
    n_checks++; if (valids != 0) $display("FAIL bounce_valids: got %0d want 0", valids); else n_pass++;
    n_checks++; if (keymap !== (64'd1 << 19)) $display("FAIL bounce_keymap: got %h want %h", keymap, 64'd1 << 19); else n_pass++;
    $display("bounce: valids=%0d keymap=%h", valids, keymap);
  endtask

  // Drives keys to a row-5 pattern and expects exactly two consecutive events.
  task automatic test_row5_pair(input bit press, input string tag);
    int codes[$];
    int cycs[$];
    int presses[$];
    int c0, c1, p0, p1, gap;
    if (press) begin
      keys = 64'd0;
      repeat (6 * FRAME) begin
        @(negedge clk);
        n_checks++; if (obs_vec !== exp_vec()) $display("FAIL %s_settle mc=%0d: got %h want %h", tag, mc, obs_vec, exp_vec()); else n_pass++;
      end
      keys[41] = 1'b1;
      keys[46] = 1'b1;
    end else begin
      keys = 64'd0;
    end
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec()) $display("FAIL %s_cycle mc=%0d: got %h want %h", tag, mc, obs_vec, exp_vec()); else n_pass++;
      if (key_valid === 1'b1) begin
        codes.push_back(int'(key_code));
        cycs.push_back(mc);
        presses.push_back(int'(key_press));
      end
    end
    c0 = codes.size() > 0 ? codes[0] : -1;
    c1 = codes.size() > 1 ? codes[1] : -1;
    p0 = presses.size() > 0 ? presses[0] : -1;
    p1 = presses.size() > 1 ? presses[1] : -1;
    gap = cycs.size() > 1 ? cycs[1] - cycs[0] : -1;
    n_checks++; if (codes.size() != 2) $display("FAIL %s_count: got %0d want 2", tag, codes.size()); else n_pass++;
    n_checks++; if (c0 != 41 || c1 != 46) $display("FAIL %s_codes: got %0d,%0d want 41,46", tag, c0, c1); else n_pass++;
    n_checks++; if (p0 != int'(press) || p1 != int'(press)) $display("FAIL %s_press: got %0d,%0d want %0d", tag, p0, p1, press); else n_pass++;
    n_checks++; if (gap != 1) $display("FAIL %s_gap: got %0d want 1", tag, gap); else n_pass++;
    n_checks++; if (keymap !== (press ? ((64'd1 << 41) | (64'd1 << 46)) : 64'd0))
      $display("FAIL %s_keymap: got %h want %h", tag, keymap, press ? ((64'd1 << 41) | (64'd1 << 46)) : 64'd0); else n_pass++;
    $display("%s: events=%0d codes=%0d,%0d press=%0d,%0d", tag, codes.size(), c0, c1, p0, p1);
  endtask

  task automatic test_reset_mid_report();
    bit found = 1'b0;
    int p41 = 0, p46 = 0, others = 0;
    keys = 64'd0;
    keys[41] = 1'b1;
    keys[46] = 1'b1;
    for (int i = 0; i < 6 * FRAME && !found; i++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec()) $display("FAIL midrst_cycle mc=%0d: got %h want %h", mc, obs_vec, exp_vec()); else n_pass++;
      if (key_valid === 1'b1 && key_code === 6'd41) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL midrst_wait: got no code 41 event want one within %0d cycles", 6 * FRAME); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", key_valid); else n_pass++;
    n_checks++; if (keymap !== 64'd0) $display("FAIL midrst_keymap: got %h want 0", keymap); else n_pass++;
    n_checks++; if (scanout !== 3'd0) $display("FAIL midrst_scanout: got %0d want 0", scanout); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec()) $display("FAIL midrst_after mc=%0d: got %h want %h", mc, obs_vec, exp_vec()); else n_pass++;
      if (key_valid === 1'b1) begin
        if (key_code === 6'd41 && key_press === 1'b1) p41++;
        else if (key_code === 6'd46 && key_press === 1'b1) p46++;
        else others++;
      end
    end
    n_checks++; if (p41 != 1 || p46 != 1 || others != 0) $display("FAIL midrst_recur: got 41x%0d 46x%0d other %0d want 1,1,0", p41, p46, others); else n_pass++;
    $display("reset_mid_report: found=%0d recur 41x%0d 46x%0d", found, p41, p46);
  endtask

  task automatic test_random();
    int hold, evs;
    for (int it = 0; it < 10; it++) begin
      keys = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
      hold = $urandom_range(300, 900);
      evs = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (it[0] && i < hold / 2 && $urandom_range(0, 5) == 0) begin
          automatic int b = $urandom_range(0, 63);
          keys[b] = ~keys[b];
        end
        n_checks++; if (obs_vec !== exp_vec()) $display("FAIL random_cycle it=%0d mc=%0d: got %h want %h", it, mc, obs_vec, exp_vec()); else n_pass++;
        if (key_valid === 1'b1) evs++;
      end
      $display("random it=%0d: keys=%h hold=%0d events=%0d keymap=%h", it, keys, hold, evs, keymap);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_idle_scan();
    test_single_press();
    test_bounce();
    test_row5_pair(1'b1, "multi_press");
    test_row5_pair(1'b0, "multi_release");
    test_reset_mid_report();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
